// File: rtl/norm_pkg.sv
// Shared types and width helpers for the post-add normalization controller.
// The optional denormal-clamping feature is selected with NORM_DENORM_EN.
package norm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DONE
  } norm_state_t;

  localparam int EMIN = 1;

  // Bits needed to hold a count in 0..n inclusive (n a power of two)
  function automatic int cntWidth(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/norm_lzc.sv
// Combinational leading-zero counter over one CHUNK-bit slice.
// Reports CHUNK when the slice is all zero.
module norm_lzc
  import norm_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0]               data_i,
  output logic [cntWidth(CHUNK)-1:0]     count_o
);

  localparam int CW = cntWidth(CHUNK);

  // Scanning upward lets the highest set bit have the final say
  always_comb begin
    count_o = CW'(CHUNK);
    for (int i = 0; i < CHUNK; i++) begin
      if (data_i[i]) begin
        count_o = CW'(CHUNK - 1 - i);
      end
    end
  end

endmodule

// File: rtl/norm_seq_ctrl.sv
// Iterative normalization controller: shifts the sum left one chunk per cycle.
// Define NORM_DENORM_EN to clamp the exponent at EMIN and emit denormals.
module norm_seq_ctrl
  import norm_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8,
  parameter int EXPW  = 11
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_sum,
  input  logic [EXPW-1:0]              in_exp,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_mant,
  output logic [EXPW-1:0]              out_exp,
  output logic [cntWidth(WIDTH)-1:0]   out_shift,
  output logic                         out_zero,
  output logic                         out_uflow,
  output logic                         busy
);

  localparam int SW = cntWidth(WIDTH);
  localparam int CW = cntWidth(CHUNK);
  localparam int EW = EXPW + 1;
  localparam logic signed [EW-1:0] EMIN_S = EW'(EMIN);

  norm_state_t             state_q, state_d;
  logic [WIDTH-1:0]        sum_q, sum_d;
  logic signed [EW-1:0]    exp_q, exp_d;
  logic [SW-1:0]           cnt_q, cnt_d;
  logic [WIDTH-1:0]        mant_q, mant_d;
  logic [EXPW-1:0]         oexp_q, oexp_d;
  logic [SW-1:0]           shift_q, shift_d;
  logic                    zero_q, zero_d;
  logic                    uflow_q, uflow_d;

  logic [CW-1:0]           lz;
  logic signed [EW-1:0]    stepS;
  logic [SW-1:0]           step;
  logic                    clamp;
  logic [WIDTH-1:0]        sumShift;
  logic signed [EW-1:0]    expNext;
  logic [SW-1:0]           cntNext;
  logic                    scanDone;
  logic                    accept;

  norm_lzc #(.CHUNK(CHUNK)) u_lzc (
    .data_i  (sum_q[WIDTH-1 -: CHUNK]),
    .count_o (lz)
  );

`ifdef NORM_DENORM_EN
  logic signed [EW-1:0] expM1;

  // Never step past EMIN; a negative budget (exp 0 on entry) means no shift at all
  always_comb begin
    expM1 = exp_q - EMIN_S;
    clamp = $signed(EW'(lz)) > expM1;
    if (clamp) begin
      stepS = expM1[EW-1] ? '0 : expM1;
    end else begin
      stepS = EW'(lz);
    end
    step = SW'(stepS);
  end
`else
  always_comb begin
    clamp = 1'b0;
    stepS = EW'(lz);
    step  = SW'(lz);
  end
`endif

  always_comb begin
    sumShift = sum_q << step;
    expNext  = exp_q - stepS;
    cntNext  = cnt_q + step;
    scanDone = (lz != CW'(CHUNK)) | clamp;
  end

  assign in_ready  = (state_q == IDLE) && !reset;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_mant  = mant_q;
  assign out_exp   = oexp_q;
  assign out_shift = shift_q;
  assign out_zero  = zero_q;
  assign out_uflow = uflow_q;

  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    exp_d   = exp_q;
    cnt_d   = cnt_q;
    mant_d  = mant_q;
    oexp_d  = oexp_q;
    shift_d = shift_q;
    zero_d  = zero_q;
    uflow_d = uflow_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          sum_d   = in_sum;
          exp_d   = {1'b0, in_exp};
          cnt_d   = '0;
          zero_d  = 1'b0;
          uflow_d = 1'b0;
          if (in_sum == '0) begin
            state_d = DONE;
            mant_d  = '0;
            oexp_d  = '0;
            shift_d = '0;
            zero_d  = 1'b1;
          end else begin
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        sum_d = sumShift;
        exp_d = expNext;
        cnt_d = cntNext;
        // Result registers are loaded only on the way into DONE
        if (scanDone) begin
          state_d = DONE;
          mant_d  = sumShift;
          shift_d = cntNext;
          oexp_d  = clamp ? EXPW'(EMIN) : expNext[EXPW-1:0];
          uflow_d = clamp | (expNext < EMIN_S);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      sum_q   <= '0;
      exp_q   <= '0;
      cnt_q   <= '0;
      mant_q  <= '0;
      oexp_q  <= '0;
      shift_q <= '0;
      zero_q  <= 1'b0;
      uflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sum_q   <= sum_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
      mant_q  <= mant_d;
      oexp_q  <= oexp_d;
      shift_q <= shift_d;
      zero_q  <= zero_d;
      uflow_q <= uflow_d;
    end
  end

endmodule

// File: tb/tb_norm_seq_ctrl.sv
// Self-checking bench for norm_seq_ctrl: fixed vectors, hand sequences and a random sweep.
// Expectations follow NORM_DENORM_EN the same way the design does.
module tb_norm_seq_ctrl;

  localparam int WIDTH = 64;
  localparam int CHUNK = 8;
  localparam int EXPW  = 11;

  typedef struct {
    logic [63:0] sum;
    logic [10:0] exp;
    logic [63:0] mant;
    logic [10:0] oexp;
    logic [6:0]  shift;
    logic        zero;
    logic        uflow;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_sum;
  logic [10:0] in_exp;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_mant;
  logic [10:0] out_exp;
  logic [6:0]  out_shift;
  logic        out_zero;
  logic        out_uflow;
  logic        busy;

  int passCount = 0;
  int checkCount = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  norm_seq_ctrl #(.WIDTH(WIDTH), .CHUNK(CHUNK), .EXPW(EXPW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sum    (in_sum),
    .in_exp    (in_exp),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mant  (out_mant),
    .out_exp   (out_exp),
    .out_shift (out_shift),
    .out_zero  (out_zero),
    .out_uflow (out_uflow),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checkCount++;
    if (act === req) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference: count leading zeros once, then apply the normalization rules arithmetically
  function automatic vec_t refModel(input logic [63:0] s, input logic [10:0] e);
    vec_t r;
    int   lead;
    int   sh;
    int   ne;
    int   budget;
    r.sum = s;
    r.exp = e;
    lead = 64;
    for (int b = 0; b < 64; b++) begin
      if (s[b]) lead = 63 - b;
    end
    if (s == 64'd0) begin
      r.mant = '0; r.oexp = '0; r.shift = '0; r.zero = 1'b1; r.uflow = 1'b0; r.lat = 1;
      return r;
    end
    r.zero = 1'b0;
    sh = lead;
    ne = int'(e) - lead;
    r.uflow = (ne < 1);
    r.oexp  = 11'(ne);
`ifdef NORM_DENORM_EN
    budget = int'(e) - 1;
    if (lead > budget) begin
      sh = (budget < 0) ? 0 : budget;
      r.oexp  = 11'd1;
      r.uflow = 1'b1;
    end
`else
    budget = 0;
`endif
    r.mant  = s << sh;
    r.shift = 7'(sh);
    r.lat   = sh / CHUNK + 2;
    return r;
  endfunction

  // Offer one operand and wait (bounded) for the result; returns cycles from accept to out_valid
  task automatic applyStimulus(input logic [63:0] s, input logic [10:0] e, output int lat);
    @(negedge clk);
    check("in_ready_before_accept", 64'(in_ready), 64'd1);
    in_sum   = s;
    in_exp   = e;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_sum   = $urandom;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic checkOutput(input vec_t v, input int lat, input int stall);
    logic [63:0] m0;
    logic [10:0] e0;
    logic [6:0]  s0;
    check("latency", 64'(lat), 64'(v.lat));
    check("out_valid", 64'(out_valid), 64'd1);
    check("out_mant", out_mant, v.mant);
    check("out_exp", 64'(out_exp), 64'(v.oexp));
    check("out_shift", 64'(out_shift), 64'(v.shift));
    check("out_zero", 64'(out_zero), 64'(v.zero));
    check("out_uflow", 64'(out_uflow), 64'(v.uflow));
    m0 = out_mant; e0 = out_exp; s0 = out_shift;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_in_ready", 64'(in_ready), 64'd0);
      check("stall_stable", {out_mant ^ m0} | 64'({out_exp ^ e0, out_shift ^ s0}), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("post_handshake_valid", 64'(out_valid), 64'd0);
    check("post_handshake_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    int lat;
    int sawValid;
    vec_t v;
    logic [63:0] s;
    logic [10:0] e;

    vecs.push_back('{64'h8000_0000_0000_0000, 11'd1023, 64'h8000_0000_0000_0000, 11'd1023, 7'd0, 1'b0, 1'b0, 2});
    vecs.push_back('{64'h1, 11'd1023, 64'h8000_0000_0000_0000, 11'd960, 7'd63, 1'b0, 1'b0, 9});
    vecs.push_back('{64'h0, 11'd500, 64'h0, 11'd0, 7'd0, 1'b1, 1'b0, 1});
    vecs.push_back('{64'h0080_0000_0000_0000, 11'd100, 64'h8000_0000_0000_0000, 11'd92, 7'd8, 1'b0, 1'b0, 3});
    vecs.push_back('{64'h3, 11'd2047, 64'hC000_0000_0000_0000, 11'd1985, 7'd62, 1'b0, 1'b0, 9});
    vecs.push_back('{64'hF000_0000_0000_0000, 11'd1, 64'hF000_0000_0000_0000, 11'd1, 7'd0, 1'b0, 1'b0, 2});
`ifdef NORM_DENORM_EN
    vecs.push_back('{64'h100, 11'd10, 64'h2_0000, 11'd1, 7'd9, 1'b0, 1'b1, 3});
    vecs.push_back('{64'h8000_0000_0000_0000, 11'd0, 64'h8000_0000_0000_0000, 11'd1, 7'd0, 1'b0, 1'b1, 2});
`else
    vecs.push_back('{64'h100, 11'd10, 64'h8000_0000_0000_0000, 11'h7D3, 7'd55, 1'b0, 1'b1, 8});
    vecs.push_back('{64'h8000_0000_0000_0000, 11'd0, 64'h8000_0000_0000_0000, 11'd0, 7'd0, 1'b0, 1'b1, 2});
`endif

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_sum = '0; in_exp = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'd0);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_outputs", out_mant | 64'({out_exp, out_shift, out_zero, out_uflow}), 64'd0);
    reset = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].sum, vecs[i].exp, lat);
      checkOutput(vecs[i], lat, 0);
    end

    // Downstream back-pressure holds the result
    applyStimulus(vecs[0].sum, vecs[0].exp, lat);
    checkOutput(vecs[0], lat, 5);

    // Reset during the second SCAN cycle drops the operation
    @(negedge clk);
    in_sum = 64'h1; in_exp = 11'd1023; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    check("scan_busy", 64'(busy), 64'd1);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    check("midreset_busy", 64'(busy), 64'd0);
    check("midreset_in_ready", 64'(in_ready), 64'd0);
    check("midreset_mant", out_mant, 64'd0);
    reset = 1'b0;
    #1;
    check("after_reset_in_ready", 64'(in_ready), 64'd1);
    sawValid = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) sawValid = 1;
    end
    check("no_result_after_reset", 64'(sawValid), 64'd0);

    // Random operands with a varied number of leading zeros
    for (int n = 0; n < 60; n++) begin
      s = {$urandom, $urandom};
      s = s >> $urandom_range(0, 64);
      e = (n % 3 == 0) ? 11'($urandom_range(0, 70)) : 11'($urandom);
      v = refModel(s, e);
      applyStimulus(s, e, lat);
      checkOutput(v, lat, $urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
